pipelined_mac: RTL and testbench

Parametrised, fully pipelined signed multiply-accumulate unit for the DCT and quantisation datapaths. It generalises the fixed 16x16, 2-stage multiplier in the following ways:
- configurable operand widths and pipeline depth
- valid-qualified streaming input
- group accumulation with clear/last framing
- round-half-up right shift and optional saturation to the output width
It accepts one product term per cycle and emits one result per accumulation group.

---
 rtl/pipelined_mac_if.sv | 18 +
 rtl/pipelined_mac.sv | 110 +++++++++++
 tb/tb_pipelined_mac.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_mac_if.sv
// Streaming term/result bundle for pipelined_mac: one product term in, one group result out.
interface pipelined_mac_if #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 32
);
  logic                        in_valid;
  logic signed [A_WIDTH-1:0]   a;
  logic signed [B_WIDTH-1:0]   b;
  logic                        clear;
  logic                        last;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out;
  logic                        overflow;

  modport master (output in_valid, a, b, clear, last, input out_valid, out, overflow);
  modport slave  (input in_valid, a, b, clear, last, output out_valid, out, overflow);
endinterface

// File: rtl/pipelined_mac.sv
// Fully pipelined signed MAC: MUL_DEPTH product stages, group accumulator with
// clear/last framing, then a round-half-up shift and optional saturation stage.
module pipelined_mac #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int MUL_DEPTH = 2,
  parameter int ACC_WIDTH = 40,
  parameter int SHIFT     = 0,
  parameter int OUT_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic           clock,
  input  logic           reset,
  pipelined_mac_if.slave mac
);
  localparam int PW = A_WIDTH + B_WIDTH;
  // One guard bit above the accumulator so the rounding add cannot wrap.
  localparam int RW = (ACC_WIDTH >= OUT_WIDTH) ? ACC_WIDTH + 1 : OUT_WIDTH + 1;
  localparam logic signed [OUT_WIDTH-1:0] OMAX_O = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OMIN_O = ~OMAX_O;
  localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  typedef struct packed {
    logic                        clr;
    logic                        lst;
    logic signed [ACC_WIDTH-1:0] prod;
  } term_t;

  logic signed [PW-1:0]         prod;
  term_t                        term_d;
  logic [MUL_DEPTH:1]           vld_pipe_q;
  term_t [MUL_DEPTH:1]          term_pipe_q;
  term_t                        acc_in;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         emit_q, emit_d;
  logic signed [RW-1:0]         sum_ext, r;
  logic signed [OUT_WIDTH-1:0]  out_q, out_d;
  logic                         ovf_q, ovf_d, out_valid_q;

  assign prod        = mac.a * mac.b;
  assign term_d.clr  = mac.clear;
  assign term_d.lst  = mac.last;
  assign term_d.prod = ACC_WIDTH'(prod);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      term_pipe_q <= '0;
    end else begin
      vld_pipe_q[1]  <= mac.in_valid;
      term_pipe_q[1] <= term_d;
      for (int i = 2; i <= MUL_DEPTH; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        term_pipe_q[i] <= term_pipe_q[i-1];
      end
    end
  end

  assign acc_in = term_pipe_q[MUL_DEPTH];

  // Bubbles leave acc untouched; clear/last only count on valid terms.
  always_comb begin
    acc_d  = acc_q;
    emit_d = 1'b0;
    if (vld_pipe_q[MUL_DEPTH]) begin
      acc_d  = (acc_in.clr ? '0 : acc_q) + acc_in.prod;
      emit_d = acc_in.lst;
    end
  end

  assign sum_ext = RW'(acc_q);

  generate
    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign r = (sum_ext + HALF) >>> SHIFT;
    end else begin : g_nornd
      assign r = sum_ext;
    end
  endgenerate

  always_comb begin
    ovf_d = (r > OMAX) || (r < OMIN);
    out_d = r[OUT_WIDTH-1:0];
    if (ovf_d && (SATURATE != 0)) out_d = r[RW-1] ? OMIN_O : OMAX_O;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      emit_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      emit_q      <= emit_d;
      out_valid_q <= emit_q;
      if (emit_q) begin
        out_q <= out_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign mac.out_valid = out_valid_q;
  assign mac.out       = out_q;
  assign mac.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_mac.sv
// Drives three MAC configurations (default, SATURATE=0, SHIFT=4) with identical
// streams and checks every cycle against an arithmetic group-sum model.
module tb_pipelined_mac;
  localparam int D = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipelined_mac_if m0 ();
  pipelined_mac_if m1 ();
  pipelined_mac_if m2 ();

  pipelined_mac u0 (.clock(clock), .reset(reset), .mac(m0));
  pipelined_mac #(.SATURATE(0)) u1 (.clock(clock), .reset(reset), .mac(m1));
  pipelined_mac #(.SHIFT(4))    u2 (.clock(clock), .reset(reset), .mac(m2));

  typedef struct {
    int     due;
    longint o0, o1, o2;
    bit     f0, f1, f2;
  } exp_t;

  exp_t   q[$];
  longint acc = 0;
  int     cyc = 0;
  int     nvec = 0, nerr = 0;
  longint h0 = 0, h1 = 0, h2 = 0;
  bit     hf0 = 0, hf1 = 0, hf2 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic longint wrap40(input longint x);
    longint m;
    m = x & ((64'sd1 <<< 40) - 1);
    if (m[39]) m = m - (64'sd1 <<< 40);
    return m;
  endfunction

  function automatic bit fits32(input longint r);
    return (r <= 64'sd2147483647) && (r >= -64'sd2147483648);
  endfunction

  function automatic longint clamp32(input longint r);
    if (r > 64'sd2147483647) return 64'sd2147483647;
    if (r < -64'sd2147483648) return -64'sd2147483648;
    return r;
  endfunction

  function automatic longint trunc32(input longint r);
    int t;
    t = int'(r);
    return longint'(t);
  endfunction

  task automatic push_result(input longint sum, input int due);
    exp_t   e;
    longint rs;
    e.due = due;
    e.f0  = !fits32(sum);
    e.o0  = clamp32(sum);
    e.f1  = !fits32(sum);
    e.o1  = trunc32(sum);
    rs    = (sum + 8) >>> 4;
    e.f2  = !fits32(rs);
    e.o2  = clamp32(rs);
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit   want;
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    want = (q.size() > 0) && (q[0].due == cyc);
    cmp("out_valid0", 64'(m0.out_valid), 64'(want));
    cmp("out_valid1", 64'(m1.out_valid), 64'(want));
    cmp("out_valid2", 64'(m2.out_valid), 64'(want));
    if (want) begin
      e  = q.pop_front();
      h0 = e.o0; h1 = e.o1; h2 = e.o2;
      hf0 = e.f0; hf1 = e.f1; hf2 = e.f2;
    end
    cmp("out0", 64'(m0.out), h0);
    cmp("out1", 64'(m1.out), h1);
    cmp("out2", 64'(m2.out), h2);
    cmp("overflow0", 64'(m0.overflow), 64'(hf0));
    cmp("overflow1", 64'(m1.overflow), 64'(hf1));
    cmp("overflow2", 64'(m2.overflow), 64'(hf2));
  endtask

  task automatic drive(input bit v, input int a, input int b, input bit c, input bit l);
    m0.in_valid = v; m0.a = 16'(a); m0.b = 16'(b); m0.clear = c; m0.last = l;
    m1.in_valid = v; m1.a = 16'(a); m1.b = 16'(b); m1.clear = c; m1.last = l;
    m2.in_valid = v; m2.a = 16'(a); m2.b = 16'(b); m2.clear = c; m2.last = l;
  endtask

  task automatic step(input bit v, input int a, input int b, input bit c, input bit l);
    @(negedge clock);
    check_cycle();
    drive(v, a, b, c, l);
    if (v) begin
      acc = wrap40((c ? 64'sd0 : acc) + longint'(a) * longint'(b));
      if (l) push_result(acc, cyc + D + 2);
    end
  endtask

  // Idle cycles carry random junk to show a/b/clear/last are ignored without valid.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
           1'($urandom), 1'($urandom));
  endtask

  task automatic model_reset();
    q.delete();
    acc = 0;
    h0 = 0; h1 = 0; h2 = 0;
    hf0 = 0; hf1 = 0; hf2 = 0;
  endtask

  initial begin
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clock);
    cmp("reset_out_valid", 64'(m0.out_valid), 64'sd0);
    cmp("reset_out", 64'(m0.out), 64'sd0);
    cmp("reset_overflow", 64'(m0.overflow), 64'sd0);
    reset = 1'b0;
    idle(2);

    // Single full-scale term.
    step(1'b1, -32768, -32768, 1'b1, 1'b1);
    idle(D + 3);
    cmp("t1_out", 64'(m0.out), 64'sd1073741824);
    cmp("t1_overflow", 64'(m0.overflow), 64'sd0);

    // Group spanning bubbles.
    step(1'b1, 3, 4, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 5, 6, 1'b0, 1'b1);
    idle(D + 4);
    cmp("t2_hold_out", 64'(m0.out), 64'sd42);
    cmp("t2_hold_valid", 64'(m0.out_valid), 64'sd0);

    // Back-to-back groups.
    step(1'b1, 1, 1, 1'b1, 1'b0);
    step(1'b1, 2, 2, 1'b0, 1'b1);
    step(1'b1, 3, 3, 1'b1, 1'b1);
    idle(D + 3);
    cmp("t3_out", 64'(m0.out), 64'sd9);

    // 64-term block of maximum products: overflows the 32-bit output.
    for (int i = 0; i < 64; i++) step(1'b1, 32767, 32767, i == 0, i == 63);
    idle(D + 3);
    cmp("t4_sat_out", 64'(m0.out), 64'sd2147483647);
    cmp("t4_sat_ovf", 64'(m0.overflow), 64'sd1);
    cmp("t4_trunc_out", 64'(m1.out), -64'sd4194240);
    cmp("t4_trunc_ovf", 64'(m1.overflow), 64'sd1);

    // Round-half-up on the SHIFT=4 instance.
    step(1'b1, 4, 6, 1'b1, 1'b1);   idle(D + 3); cmp("t5_24", 64'(m2.out), 64'sd2);
    step(1'b1, 23, 1, 1'b1, 1'b1);  idle(D + 3); cmp("t5_23", 64'(m2.out), 64'sd1);
    step(1'b1, -4, 6, 1'b1, 1'b1);  idle(D + 3); cmp("t5_m24", 64'(m2.out), -64'sd1);
    step(1'b1, -8, 1, 1'b1, 1'b1);  idle(D + 3); cmp("t5_m8", 64'(m2.out), 64'sd0);

    // Reset in the middle of a group.
    step(1'b1, 7, 7, 1'b1, 1'b0);
    step(1'b1, 9, 9, 1'b0, 1'b0);
    @(negedge clock);
    check_cycle();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    cmp("t6_async_out", 64'(m0.out), 64'sd0);
    cmp("t6_async_valid", 64'(m0.out_valid), 64'sd0);
    cmp("t6_async_out2", 64'(m2.out), 64'sd0);
    model_reset();
    @(negedge clock);
    check_cycle();
    reset = 1'b0;
    idle(D + 4);
    step(1'b1, 2, 3, 1'b1, 1'b1);
    idle(D + 3);
    cmp("t6_new_group", 64'(m0.out), 64'sd6);

    // Random streams with bubbles, framing and back-to-back groups.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0),
           $urandom_range(0, 65535) - 32768,
           $urandom_range(0, 65535) - 32768,
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) == 0));
    end
    // Long group that saturates the shifted instance as well.
    for (int i = 0; i < 40; i++) step(1'b1, -32768, 32767, i == 0, i == 39);
    idle(D + 6);
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
